// File: rtl/buffer_pkg.sv
// Shared width helpers for the instant-buffer pointer/occupancy logic.
package buffer_pkg;
   function automatic int ptr_w(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   function automatic int cnt_w(input int size);
      return $clog2(size + 1);
   endfunction
endpackage

// File: rtl/mod_counter.sv
// Wrapping pointer: advances by STEP modulo 2**WIDTH; rst beats clr beats inc.
module mod_counter #(
   parameter int WIDTH = 3,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] val
);
   // STEP == 2**WIDTH truncates to zero, which is the correct modulo step.
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   always_ff @(posedge clk) begin
      if (rst)      val <= '0;
      else if (clr) val <= '0;
      else if (inc) val <= val + STEP_W;
   end
endmodule

// File: rtl/instant_buffer_ctrl.sv
// Pointer and occupancy control for an external instant_buffer; the
// block holds no storage, it only drives write/read base addresses.
module instant_buffer_ctrl
   import buffer_pkg::*;
#(
   parameter int SIZE       = 8,
   parameter int WRITE_SIZE = 2,
   parameter int READ_SIZE  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic                     buf_write_en,
   output logic [ptr_w(SIZE)-1:0]   buf_write_addr,
   output logic [ptr_w(SIZE)-1:0]   buf_read_addr,
   output logic [cnt_w(SIZE)-1:0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PW = ptr_w(SIZE);
   localparam int CW = cnt_w(SIZE);
   localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
   localparam logic [CW-1:0] WR_C   = CW'(WRITE_SIZE);
   localparam logic [CW-1:0] RD_C   = CW'(READ_SIZE);

   if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
      $error("SIZE must be a power of two and at least 2");
   end
   if (WRITE_SIZE < 1 || WRITE_SIZE > SIZE) begin : g_bad_wr
      $error("WRITE_SIZE must be in 1..SIZE");
   end
   if (READ_SIZE < 1 || READ_SIZE > SIZE) begin : g_bad_rd
      $error("READ_SIZE must be in 1..SIZE");
   end

   logic          push, pop;
   logic [CW-1:0] count_nxt;

   // Ready/valid come only from registered count, so no same-cycle pass-through.
   assign wr_ready = (SIZE_C - count) >= WR_C;
   assign rd_valid = count >= RD_C;
   assign full     = count == SIZE_C;
   assign empty    = count == '0;

   assign push         = wr_valid && wr_ready;
   assign pop          = rd_valid && rd_ready;
   assign buf_write_en = push && !flush && !rst;

   always_comb begin
      count_nxt = count;
      if (push) count_nxt = count_nxt + WR_C;
      if (pop)  count_nxt = count_nxt - RD_C;
   end

   always_ff @(posedge clk) begin
      if (rst)        count <= '0;
      else if (flush) count <= '0;
      else            count <= count_nxt;
   end

   mod_counter #(.WIDTH(PW), .STEP(WRITE_SIZE)) u_wp (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (push),
      .val (buf_write_addr)
   );

   mod_counter #(.WIDTH(PW), .STEP(READ_SIZE)) u_rp (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (pop),
      .val (buf_read_addr)
   );
endmodule

// File: tb/tb_instant_buffer_ctrl.sv
// Directed bench: SIZE=8 controller with W=2/R=2 and a second with W=2/R=4.
module tb_instant_buffer_ctrl;
   logic       clk = 1'b0;
   logic       rst, flush, wr_valid, rd_ready, wr_valid4, rd_ready4;
   logic       wr_ready, rd_valid, bwe, full, empty;
   logic [2:0] wa, ra;
   logic [3:0] cnt;
   logic       wr_ready4, rd_valid4, bwe4, full4, empty4;
   logic [2:0] wa4, ra4;
   logic [3:0] cnt4;
   logic [7:0] mem [8];
   logic [7:0] wd0, wd1;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   instant_buffer_ctrl #(.SIZE(8), .WRITE_SIZE(2), .READ_SIZE(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .buf_write_en(bwe),
      .buf_write_addr(wa), .buf_read_addr(ra), .count(cnt), .full(full), .empty(empty)
   );

   instant_buffer_ctrl #(.SIZE(8), .WRITE_SIZE(2), .READ_SIZE(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid4), .wr_ready(wr_ready4),
      .rd_valid(rd_valid4), .rd_ready(rd_ready4), .buf_write_en(bwe4),
      .buf_write_addr(wa4), .buf_read_addr(ra4), .count(cnt4), .full(full4), .empty(empty4)
   );

   // Stand-in for the instant_buffer storage: two entries per push.
   always @(posedge clk) begin
      if (bwe) begin
         mem[wa]        <= wd0;
         mem[wa + 3'd1] <= wd1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; flush = 0; wr_valid = 0; rd_ready = 0; wr_valid4 = 0; rd_ready4 = 0;
      tick(); tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; flush = 0; wr_valid = 1; rd_ready = 0; wr_valid4 = 1; rd_ready4 = 0;
      wd0 = 8'h00; wd1 = 8'h00;
      #1;
      checks++;
      if ({bwe, bwe4} !== 2'b00) begin errors++; $display("FAIL rst_wen got %b exp 00", {bwe, bwe4}); end
      tick();
      checks++;
      if (bwe !== 1'b0) begin errors++; $display("FAIL rst_wen_held got %b exp 0", bwe); end
      rst = 0; wr_valid = 0; wr_valid4 = 0;
      tick();
      checks++;
      if ({empty, full, rd_valid, wr_ready} !== 4'b1001) begin
         errors++; $display("FAIL rst_flags got %b exp 1001", {empty, full, rd_valid, wr_ready});
      end
      checks++;
      if (cnt !== 4'd0 || ra !== 3'd0 || wa !== 3'd0) begin
         errors++; $display("FAIL rst_state got cnt=%0d ra=%0d wa=%0d exp 0 0 0", cnt, ra, wa);
      end
      checks++;
      if ({empty4, rd_valid4, wr_ready4, cnt4} !== {3'b101, 4'd0}) begin
         errors++; $display("FAIL rst_dut4 got %b exp 1010000", {empty4, rd_valid4, wr_ready4, cnt4});
      end
   endtask

   task automatic test_fill();
      wr_valid = 1; rd_ready = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (cnt !== 4'(2 * (i + 1))) begin
            errors++; $display("FAIL fill_count_%0d got %0d exp %0d", i, cnt, 2 * (i + 1));
         end
      end
      checks++;
      if ({full, wr_ready, bwe} !== 3'b100) begin
         errors++; $display("FAIL fill_full got %b exp 100", {full, wr_ready, bwe});
      end
      tick();
      checks++;
      if (cnt !== 4'd8 || wa !== 3'd0) begin
         errors++; $display("FAIL fill_blocked got cnt=%0d wa=%0d exp 8 0", cnt, wa);
      end
      wr_valid = 0;
   endtask

   task automatic test_full_pushpop();
      wr_valid = 1; rd_ready = 1;
      #1;
      checks++;
      if ({wr_ready, rd_valid, bwe} !== 3'b010) begin
         errors++; $display("FAIL fullpp_hs got %b exp 010", {wr_ready, rd_valid, bwe});
      end
      tick();
      checks++;
      if (cnt !== 4'd6 || ra !== 3'd2 || wa !== 3'd0) begin
         errors++; $display("FAIL fullpp_pop got cnt=%0d ra=%0d wa=%0d exp 6 2 0", cnt, ra, wa);
      end
      tick();
      checks++;
      if (cnt !== 4'd6 || ra !== 3'd4 || wa !== 3'd2) begin
         errors++; $display("FAIL fullpp_both got cnt=%0d ra=%0d wa=%0d exp 6 4 2", cnt, ra, wa);
      end
      wr_valid = 0; rd_ready = 0;
   endtask

   task automatic test_wrap();
      do_reset();
      wr_valid = 1;
      repeat (3) tick();
      wr_valid = 0; rd_ready = 1;
      repeat (3) tick();
      rd_ready = 0;
      checks++;
      if (wa !== 3'd6 || ra !== 3'd6 || cnt !== 4'd0) begin
         errors++; $display("FAIL wrap_setup got wa=%0d ra=%0d cnt=%0d exp 6 6 0", wa, ra, cnt);
      end
      wd0 = 8'hA6; wd1 = 8'hB7; wr_valid = 1;
      #1;
      checks++;
      if (bwe !== 1'b1) begin errors++; $display("FAIL wrap_wen got %b exp 1", bwe); end
      tick();
      wr_valid = 0;
      checks++;
      if (wa !== 3'd0 || cnt !== 4'd2 || rd_valid !== 1'b1) begin
         errors++; $display("FAIL wrap_wp got wa=%0d cnt=%0d rdv=%b exp 0 2 1", wa, cnt, rd_valid);
      end
      checks++;
      if (ra !== 3'd6 || mem[ra] !== 8'hA6 || mem[ra + 3'd1] !== 8'hB7) begin
         errors++; $display("FAIL wrap_data got ra=%0d d=%h %h exp 6 a6 b7", ra, mem[ra], mem[ra + 3'd1]);
      end
      rd_ready = 1;
      tick();
      rd_ready = 0;
      checks++;
      if (ra !== 3'd0 || empty !== 1'b1) begin
         errors++; $display("FAIL wrap_rp got ra=%0d empty=%b exp 0 1", ra, empty);
      end
   endtask

   task automatic test_read4();
      wr_valid4 = 1;
      tick();
      checks++;
      if (cnt4 !== 4'd2 || rd_valid4 !== 1'b0) begin
         errors++; $display("FAIL r4_first got cnt=%0d rdv=%b exp 2 0", cnt4, rd_valid4);
      end
      tick();
      wr_valid4 = 0;
      checks++;
      if (cnt4 !== 4'd4 || rd_valid4 !== 1'b1) begin
         errors++; $display("FAIL r4_second got cnt=%0d rdv=%b exp 4 1", cnt4, rd_valid4);
      end
      rd_ready4 = 1;
      tick();
      rd_ready4 = 0;
      checks++;
      if (cnt4 !== 4'd0 || empty4 !== 1'b1 || ra4 !== 3'd4) begin
         errors++; $display("FAIL r4_pop got cnt=%0d empty=%b ra=%0d exp 0 1 4", cnt4, empty4, ra4);
      end
   endtask

   task automatic test_flush(input logic with_rst);
      do_reset();
      wr_valid = 1;
      repeat (4) tick();
      wr_valid = 0; rd_ready = 1;
      tick();
      checks++;
      if (cnt !== 4'd6 || ra !== 3'd2) begin
         errors++; $display("FAIL flush_setup_%0d got cnt=%0d ra=%0d exp 6 2", with_rst, cnt, ra);
      end
      flush = 1; rst = with_rst; wr_valid = 1; rd_ready = 1;
      #1;
      checks++;
      if (bwe !== 1'b0) begin errors++; $display("FAIL flush_wen_%0d got %b exp 0", with_rst, bwe); end
      tick();
      flush = 0; rst = 0; wr_valid = 0; rd_ready = 0;
      checks++;
      if (wa !== 3'd0 || ra !== 3'd0 || cnt !== 4'd0) begin
         errors++; $display("FAIL flush_state_%0d got wa=%0d ra=%0d cnt=%0d exp 0 0 0", with_rst, wa, ra, cnt);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_pushpop();
      test_wrap();
      test_read4();
      test_flush(1'b0);
      test_flush(1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
